channel_collector: RTL and testbench
====================================

CHANNEL_COLLECTOR -- requirements
Module: channel_collector

Interface
REQ-001 SHALL have parameter N, default 16, meaning per-channel data width in bits.
REQ-002 SHALL have parameter CHANNELS, default 16, meaning channels per pixel vector (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_in  input  N  activation beat from the upstream activation stage.
REQ-006 SHALL have port channel_in  input  $clog2(CHANNELS)  channel index of data_in.
REQ-007 SHALL have port valid_in  input  1  data_in/channel_in qualifier; no backpressure upstream.
REQ-008 SHALL have port pixel_data  output  N*CHANNELS  packed vector, channel c at bits [c*N +: N].
REQ-009 SHALL have port pixel_valid  output  1  pixel_data holds a complete vector.
REQ-010 SHALL have port pixel_ready  input  1  downstream accepts pixel_data.
REQ-011 SHALL have port overflow  output  1  sticky: a beat was dropped for lack of a free bank.
REQ-012 SHALL have port seq_error  output  1  sticky: channel order violation (CHANNEL_CHECK_EN only).

Function
REQ-013 SHALL hold two banks (0,1), each CHANNELS x N registers plus a FULL flag; wr_bank, rd_bank pointers, and lane counter cnt.
REQ-014 SHALL, when valid_in=1 and bank[wr_bank] writable, store data_in into lane cnt of bank[wr_bank] and increment cnt.
REQ-015 SHALL, on the beat written at lane CHANNELS-1, set FULL of that bank, wrap cnt to 0, toggle wr_bank on the same edge.
REQ-016 SHALL assert pixel_valid on the cycle after the completing beat (1-cycle latency), driven by FULL of bank[rd_bank].
REQ-017 SHALL drive pixel_data from bank[rd_bank] registers; pixel_data SHALL be stable while pixel_valid=1 and pixel_ready=0.
REQ-018 SHALL complete a transfer when pixel_valid=1 and pixel_ready=1: clear FULL of rd_bank, toggle rd_bank on that edge.
REQ-019 SHALL treat a bank as writable if FULL=0 or it is being transferred in the same cycle (same-cycle free and write: beat accepted).
REQ-020 SHALL drop a valid_in beat whose target bank is FULL and not being transferred, leave cnt unchanged, and set overflow.
REQ-021 SHALL allow completion of one bank and transfer of the other in the same cycle without loss.
REQ-022 SHALL sustain one beat per cycle indefinitely when pixel_ready=1 continuously.
REQ-023 SHALL ignore data_in/channel_in when valid_in=0; bank contents unchanged.

Reset
REQ-024 SHALL, on rst=1, clear pixel_data to 0, pixel_valid, overflow, seq_error to 0, both FULL flags, cnt, wr_bank, rd_bank to 0.
REQ-025 SHALL discard any partial or full vector when rst asserts mid-operation; first valid beat after rst deasserts lands at lane 0, bank 0.

Configuration
REQ-026 SHALL, with macro CHANNEL_CHECK_EN defined, compare channel_in with cnt on each accepted beat.
REQ-027 SHALL, under CHANNEL_CHECK_EN on mismatch, set seq_error, discard the partial vector in bank[wr_bank], and: if channel_in=0 write the beat at lane 0 and set cnt=1, else drop it and set cnt=0.
REQ-028 SHALL, without CHANNEL_CHECK_EN, ignore channel_in (lane = cnt) and tie seq_error to 0.

Verification (N=16, CHANNELS=4)
REQ-029 SHALL cover: beats 0x0001..0x0004 on ch 0..3, pixel_ready=1 -> pixel_valid one cycle after 4th beat, pixel_data=0x0004_0003_0002_0001, single-cycle pulse.
REQ-030 SHALL cover: 12 back-to-back beats, pixel_ready=0 -> banks fill after beats 4 and 8, beats 9..12 dropped, overflow=1, first vector held stable.
REQ-031 SHALL cover: continuous stream of 16 beats, pixel_ready=1 -> 4 vectors in order, no drop, overflow=0.
REQ-032 SHALL cover: both banks full, pixel_ready raised in the cycle beat 9 arrives -> beat 9 accepted into freed bank 0, overflow=0.
REQ-033 SHALL cover: rst pulsed after 2 beats -> outputs 0; next 4 beats (ch 0..3) form a clean vector.
REQ-034 SHALL cover (CHANNEL_CHECK_EN): ch sequence 0,1,3 -> seq_error=1, partial discarded; then 0,1,2,3 -> valid vector produced.

Source files
------------

// File: rtl/channel_collector_if.sv
// Channel collector bus interface.
// Groups the upstream beat stream (data_in/channel_in/valid_in) and the
// downstream pixel-vector handshake (pixel_data/pixel_valid/pixel_ready)
// together with the sticky status flags (overflow, seq_error).
//   master : upstream/downstream environment (drives beats and pixel_ready)
//   slave  : channel_collector (consumes beats, produces pixel vectors)
interface channel_collector_if #(
    parameter int unsigned N        = 16,
    parameter int unsigned CHANNELS = 16
);
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [N-1:0]          data_in;
    logic [CW-1:0]         channel_in;
    logic                  valid_in;
    logic [N*CHANNELS-1:0] pixel_data;
    logic                  pixel_valid;
    logic                  pixel_ready;
    logic                  overflow;
    logic                  seq_error;

    modport master (
        output data_in, channel_in, valid_in, pixel_ready,
        input  pixel_data, pixel_valid, overflow, seq_error
    );

    modport slave (
        input  data_in, channel_in, valid_in, pixel_ready,
        output pixel_data, pixel_valid, overflow, seq_error
    );
endinterface

// File: rtl/channel_collector.sv
// Channel collector: gathers CHANNELS consecutive N-bit activation beats
// into one packed pixel vector using two ping-pong banks, and presents each
// completed vector downstream with a valid/ready handshake.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - channel_collector_if.slave (beat input, pixel output, status)
// Optional feature: define CHANNEL_CHECK_EN to check channel_in against the
// expected lane on every accepted beat and flag/recover order violations.
module channel_collector #(
    parameter int unsigned N        = 16,
    parameter int unsigned CHANNELS = 16
) (
    input  logic              clk,
    input  logic              rst,
    channel_collector_if.slave bus
);
    localparam int unsigned CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    logic [N-1:0]  r_bank [2][CHANNELS];
    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [CW-1:0] r_cnt;
    logic          r_overflow;

    logic          w_xfer;
    logic          w_wr_free;
    logic          w_accept;
    logic          w_drop;
    logic          w_in_order;
    logic          w_we;
    logic [CW-1:0] w_lane;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_complete;

    // Handshake and bank availability; a bank leaving this cycle is writable.
    assign w_xfer    = r_full[r_rd_bank] & bus.pixel_ready;
    assign w_wr_free = ~r_full[r_wr_bank] | (w_xfer & (r_rd_bank == r_wr_bank));
    assign w_accept  = bus.valid_in & w_wr_free;
    assign w_drop    = bus.valid_in & ~w_wr_free;

`ifdef CHANNEL_CHECK_EN
    logic r_seq_error;
    logic w_seq_set;

    assign w_in_order    = (bus.channel_in == r_cnt);
    assign bus.seq_error = r_seq_error;
`else
    logic w_unused_channel;

    // Lane is taken from the counter alone; channel_in is not consulted.
    assign w_in_order       = 1'b1;
    assign w_unused_channel = ^bus.channel_in;
    assign bus.seq_error    = 1'b0;
`endif

    // Lane write / counter next-state.
    always_comb begin
        w_we       = 1'b0;
        w_lane     = r_cnt;
        w_cnt_nxt  = r_cnt;
        w_complete = 1'b0;
`ifdef CHANNEL_CHECK_EN
        w_seq_set  = 1'b0;
`endif
        if (w_accept) begin
            if (w_in_order) begin
                w_we = 1'b1;
                if (r_cnt == LAST) begin
                    w_complete = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
`ifdef CHANNEL_CHECK_EN
            else begin
                // Out-of-order beat: abandon the partial vector; a channel-0
                // beat is taken as the start of a fresh vector.
                w_seq_set = 1'b1;
                if (bus.channel_in == '0) begin
                    w_we      = 1'b1;
                    w_lane    = '0;
                    w_cnt_nxt = CW'(1);
                end else begin
                    w_cnt_nxt = '0;
                end
            end
`endif
        end
    end

    // Bank storage, pointers and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_bank[b][c] <= '0;
                end
            end
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
`ifdef CHANNEL_CHECK_EN
            r_seq_error <= 1'b0;
`endif
        end else begin
            if (w_we) begin
                r_bank[r_wr_bank][w_lane] <= bus.data_in;
            end
            // Clear before set so a same-cycle refill of a freed bank wins.
            if (w_xfer) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (w_complete) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            r_cnt <= w_cnt_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
`ifdef CHANNEL_CHECK_EN
            if (w_seq_set) begin
                r_seq_error <= 1'b1;
            end
`endif
        end
    end

    // Output vector straight from the read bank's registers.
    always_comb begin
        bus.pixel_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.pixel_data[c*N +: N] = r_bank[r_rd_bank][c];
        end
    end

    assign bus.pixel_valid = r_full[r_rd_bank];
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_channel_collector.sv
// Directed, table-driven bench for channel_collector (N=16, CHANNELS=4).
// Each table row is one clock cycle: inputs are driven and the outputs
// (which reflect state after the previous edge) are compared at the falling
// edge. Hand-written sequences cover stall stability and a same-edge
// completion/transfer of opposite banks.
module tb_channel_collector;
    localparam int unsigned N  = 16;
    localparam int unsigned CH = 4;

    typedef struct {
        logic        rs;
        logic        v;
        logic [1:0]  ch;
        logic [15:0] d;
        logic        rdy;
        logic        chk;
        logic        ev;
        logic [63:0] ed;
        logic        cd;
        logic        eo;
        logic        es;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    channel_collector_if #(.N(N), .CHANNELS(CH)) bus ();

    channel_collector #(.N(N), .CHANNELS(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic rs, input logic v, input int ch, input logic [15:0] d,
                           input logic rdy, input logic chk, input logic ev,
                           input logic [63:0] ed, input logic cd, input logic eo,
                           input logic es);
        vec_t r;
        r.rs = rs; r.v = v; r.ch = 2'(ch); r.d = d; r.rdy = rdy;
        r.chk = chk; r.ev = ev; r.ed = ed; r.cd = cd; r.eo = eo; r.es = es;
        tbl.push_back(r);
    endtask

    task automatic beat(input int ch, input logic [15:0] d, input logic rdy, input logic ev,
                        input logic [63:0] ed, input logic eo, input logic es);
        add_row(1'b0, 1'b1, ch, d, rdy, 1'b1, ev, ed, ev, eo, es);
    endtask

    task automatic idle(input logic rdy, input logic ev, input logic [63:0] ed,
                        input logic eo, input logic es);
        add_row(1'b0, 1'b0, 0, 16'h0, rdy, 1'b1, ev, ed, ev, eo, es);
    endtask

    // Reset cycle followed by a check that every output is cleared.
    task automatic reset_rows();
        add_row(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic apply(input int idx, input vec_t r);
        rst             = r.rs;
        bus.valid_in    = r.v;
        bus.channel_in  = r.ch;
        bus.data_in     = r.d;
        bus.pixel_ready = r.rdy;
        if (r.chk) begin
            cmp($sformatf("row%0d_valid", idx), 64'(bus.pixel_valid), 64'(r.ev));
            cmp($sformatf("row%0d_overflow", idx), 64'(bus.overflow), 64'(r.eo));
            cmp($sformatf("row%0d_seq_error", idx), 64'(bus.seq_error), 64'(r.es));
            if (r.cd) begin
                cmp($sformatf("row%0d_data", idx), bus.pixel_data, r.ed);
            end
        end
    endtask

    task automatic drive(input logic v, input int ch, input logic [15:0] d, input logic rdy);
        bus.valid_in    = v;
        bus.channel_in  = 2'(ch);
        bus.data_in     = d;
        bus.pixel_ready = rdy;
    endtask

    initial begin
        logic [63:0] ed;
        int          n;

        rst             = 1'b1;
        bus.valid_in    = 1'b0;
        bus.channel_in  = '0;
        bus.data_in     = '0;
        bus.pixel_ready = 1'b0;

        // Single vector, ready high: one-cycle valid pulse.
        reset_rows();
        beat(0, 16'h0001, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(1, 16'h0002, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(2, 16'h0003, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(3, 16'h0004, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

        // 12 beats with ready low: both banks fill, beats 9..12 dropped.
        reset_rows();
        for (int i = 1; i <= 12; i++) begin
            beat((i - 1) % 4, 16'(16'h0010 + i), 1'b0, (i >= 5),
                 64'h0014_0013_0012_0011, (i >= 10), 1'b0);
        end
        idle(1'b0, 1'b1, 64'h0014_0013_0012_0011, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 64'h0014_0013_0012_0011, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 64'h0018_0017_0016_0015, 1'b1, 1'b0);
        idle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);

        // Both banks full; ready rises in the cycle beat 9 arrives.
        reset_rows();
        for (int i = 1; i <= 8; i++) begin
            beat((i - 1) % 4, 16'(16'h0020 + i), 1'b0, (i >= 5),
                 64'h0024_0023_0022_0021, 1'b0, 1'b0);
        end
        beat(0, 16'h0029, 1'b1, 1'b1, 64'h0024_0023_0022_0021, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 64'h0028_0027_0026_0025, 1'b0, 1'b0);
        beat(1, 16'h002A, 1'b1, 1'b1, 64'h0028_0027_0026_0025, 1'b0, 1'b0);
        beat(2, 16'h002B, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(3, 16'h002C, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 64'h002C_002B_002A_0029, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

        // Continuous 16-beat stream with ready high: four vectors, no drop.
        reset_rows();
        for (int i = 1; i <= 16; i++) begin
            ed = pack4(16'(16'h0040 + i - 4), 16'(16'h0040 + i - 3),
                       16'(16'h0040 + i - 2), 16'(16'h0040 + i - 1));
            beat((i - 1) % 4, 16'(16'h0040 + i), 1'b1, (i > 1) && (i % 4 == 1), ed, 1'b0, 1'b0);
        end
        idle(1'b1, 1'b1, 64'h0050_004F_004E_004D, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

        // Reset after two beats: next four beats form a clean vector.
        reset_rows();
        beat(0, 16'h0061, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(1, 16'h0062, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        reset_rows();
        beat(0, 16'h0071, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(1, 16'h0072, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(2, 16'h0073, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(3, 16'h0074, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 64'h0074_0073_0072_0071, 1'b0, 1'b0);

        // Channel sequence 0,1,3 then more beats.
        reset_rows();
        beat(0, 16'h0081, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(1, 16'h0082, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat(3, 16'h0083, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
`ifdef CHANNEL_CHECK_EN
        beat(0, 16'h0091, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        beat(1, 16'h0092, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        beat(2, 16'h0093, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        beat(3, 16'h0094, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        beat(0, 16'h00A1, 1'b1, 1'b1, 64'h0094_0093_0092_0091, 1'b0, 1'b1);
        beat(0, 16'h00A2, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        beat(1, 16'h00A3, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        beat(2, 16'h00A4, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        beat(3, 16'h00A5, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        idle(1'b1, 1'b1, 64'h00A5_00A4_00A3_00A2, 1'b0, 1'b1);
`else
        beat(0, 16'h0084, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 64'h0084_0083_0082_0081, 1'b0, 1'b0);
`endif
        idle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply(i, tbl[i]);
        end

        // Hand sequence: stalled vector held stable while the other bank
        // fills; its last beat lands on the edge that transfers the first.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 0, 16'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, i, 16'(16'h00B1 + i), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 0, 16'h0, 1'b0);
        n = 0;
        while (!bus.pixel_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        cmp("hs_wait_valid", 64'(bus.pixel_valid), 64'h1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 16'(16'h00B5 + i), 1'b0);
            cmp($sformatf("hs_stall%0d_valid", i), 64'(bus.pixel_valid), 64'h1);
            cmp($sformatf("hs_stall%0d_data", i), bus.pixel_data, 64'h00B4_00B3_00B2_00B1);
            @(negedge clk);
        end
        drive(1'b1, 3, 16'h00B8, 1'b1);
        cmp("hs_xfer0_data", bus.pixel_data, 64'h00B4_00B3_00B2_00B1);
        @(negedge clk);
        drive(1'b0, 0, 16'h0, 1'b0);
        cmp("hs_bank1_valid", 64'(bus.pixel_valid), 64'h1);
        cmp("hs_bank1_data", bus.pixel_data, 64'h00B8_00B7_00B6_00B5);
        cmp("hs_overflow", 64'(bus.overflow), 64'h0);
        @(negedge clk);
        drive(1'b0, 0, 16'h0, 1'b1);
        cmp("hs_hold_valid", 64'(bus.pixel_valid), 64'h1);
        @(negedge clk);
        drive(1'b0, 0, 16'h0, 1'b0);
        cmp("hs_drained_valid", 64'(bus.pixel_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
